// File: rtl/float2fix_if.sv
// float2fix_if: operand and result bundle of the float-to-fixed converter.
// The producer/consumer side takes the master modport; the converter takes slave.
interface float2fix_if;
    logic        src_valid;
    logic [31:0] src;
    logic [31:0] fraction_len;
    logic        dst_valid;
    logic [31:0] dst;

    modport master (
        output src_valid, src, fraction_len,
        input  dst_valid, dst
    );

    modport slave (
        input  src_valid, src, fraction_len,
        output dst_valid, dst
    );
endinterface

// File: rtl/float2fix.sv
// float2fix: IEEE-754 single to signed 32-bit fixed point with a per-operand
// fractional bit count. Operands are captured on an enabled edge and leave the
// S3 result register three enabled edges later. Rounding is to nearest with
// ties away from zero; out-of-range values and infinities saturate, while NaN,
// zero and denormal inputs give zero.
module float2fix (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    float2fix_if.slave bus
);

    // Capture register: raw operand plus its clamped fraction length
    logic        vld_p0_q;
    logic [31:0] src_p0_q;
    logic [4:0]  f_p0_q;
    logic [4:0]  f_p0_d;

    // S1: unpack / classify / shift amount
    logic              vld_p1_q;
    logic              sign_p1_q,  sign_p1_d;
    logic              zero_p1_q,  zero_p1_d;
    logic              inf_p1_q,   inf_p1_d;
    logic [23:0]       sig_p1_q,   sig_p1_d;
    logic signed [9:0] sh_p1_q,    sh_p1_d;

    // S2: aligned magnitude with guard and sticky
    logic        vld_p2_q;
    logic        sign_p2_q, sign_p2_d;
    logic        zero_p2_q, zero_p2_d;
    logic        sat_p2_q,  sat_p2_d;
    logic [31:0] mag_p2_q,  mag_p2_d;
    logic        grd_p2_q,  grd_p2_d;
    logic        stk_p2_q,  stk_p2_d;

    // S3: result
    logic        vld_p3_q;
    logic [31:0] dst_q, dst_d;

    // Alignment temporaries
    logic        ovf;
    logic [9:0]  rsh;
    logic [71:0] ext;

    // Magnitude at or above one half of an LSB rounds away from zero, so an
    // exact tie and an above-half remainder both increment.
    function automatic logic [32:0] round_mag(input logic [31:0] mag,
                                              input logic grd, input logic stk);
        logic inc;
        inc = (grd & stk) | (grd & ~stk);
        return {1'b0, mag} + {32'h0, inc};
    endfunction

    // Applies the sign after rounding and clamps to the signed 32-bit range.
    function automatic logic [31:0] sat_fix(input logic sign, input logic zero,
                                            input logic sat, input logic [32:0] rmag);
        if (zero)
            return 32'h0000_0000;
        if (sat)
            return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (!sign)
            return (rmag > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : rmag[31:0];
        if (rmag > 33'h0_8000_0000)
            return 32'h8000_0000;
        return 32'(-rmag[31:0]);
    endfunction

    // Clamp the requested fraction length to 31 before it enters the pipe
    always_comb begin
        f_p0_d = (|bus.fraction_len[31:5]) ? 5'd31 : bus.fraction_len[4:0];
    end

    // ---- p0 -> p1: unpack fields, classify, signed shift exp-127+F-23 ----
    always_comb begin
        sign_p1_d = src_p0_q[31];
        zero_p1_d = (src_p0_q[30:23] == 8'h00) ||
                    ((src_p0_q[30:23] == 8'hFF) && (src_p0_q[22:0] != 23'h0));
        inf_p1_d  = (src_p0_q[30:23] == 8'hFF) && (src_p0_q[22:0] == 23'h0);
        sig_p1_d  = {1'b1, src_p0_q[22:0]};
        sh_p1_d   = $signed({2'b00, src_p0_q[30:23]}) + $signed({5'b00000, f_p0_q})
                    - 10'sd150;
    end

    // ---- p1 -> p2: align; left shifts past bit 31 flag overflow first ----
    always_comb begin
        mag_p2_d  = 32'h0;
        grd_p2_d  = 1'b0;
        stk_p2_d  = 1'b0;
        ovf       = 1'b0;
        rsh       = 10'h0;
        ext       = 72'h0;
        if (!sh_p1_q[9]) begin
            if (sh_p1_q > 10'sd8)
                ovf = 1'b1;
            else
                mag_p2_d = {8'h00, sig_p1_q} << sh_p1_q[3:0];
        end else begin
            rsh = -sh_p1_q;
            if (rsh > 10'd48) begin
                // Every significand bit lies below the guard position
                stk_p2_d = 1'b1;
            end else begin
                ext      = {sig_p1_q, 48'h0} >> rsh[5:0];
                mag_p2_d = {8'h00, ext[71:48]};
                grd_p2_d = ext[47];
                stk_p2_d = |ext[46:0];
            end
        end
        sign_p2_d = sign_p1_q;
        zero_p2_d = zero_p1_q;
        sat_p2_d  = !zero_p1_q && (inf_p1_q || ovf);
    end

    // ---- p2 -> p3: round, negate, saturate ----
    always_comb begin
        dst_d = sat_fix(sign_p2_q, zero_p2_q, sat_p2_q,
                        round_mag(mag_p2_q, grd_p2_q, stk_p2_q));
    end

    // Data path registers advance together on enable; valid bits qualify them
    always_ff @(posedge clk) begin
        if (enable) begin
            src_p0_q  <= bus.src;
            f_p0_q    <= f_p0_d;
            sign_p1_q <= sign_p1_d;
            zero_p1_q <= zero_p1_d;
            inf_p1_q  <= inf_p1_d;
            sig_p1_q  <= sig_p1_d;
            sh_p1_q   <= sh_p1_d;
            sign_p2_q <= sign_p2_d;
            zero_p2_q <= zero_p2_d;
            sat_p2_q  <= sat_p2_d;
            mag_p2_q  <= mag_p2_d;
            grd_p2_q  <= grd_p2_d;
            stk_p2_q  <= stk_p2_d;
        end
    end

    // Valid chain and result register; dst only changes for a valid operand
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            dst_q    <= 32'h0;
        end else if (enable) begin
            vld_p0_q <= bus.src_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q)
                dst_q <= dst_d;
        end
    end

    assign bus.dst       = dst_q;
    assign bus.dst_valid = vld_p3_q;

endmodule

// File: tb/tb_float2fix.sv
// tb_float2fix: directed vectors with hand-computed results for float2fix.
module tb_float2fix;

    logic clk;
    logic rstn;
    logic enable;
    int   n_cmp = 0;
    int   n_err = 0;

    float2fix_if bus ();

    float2fix dut (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated operand: accepted at edge N, silent at N+2, present at N+3
    task automatic single(input string tag, input logic [31:0] s,
                          input logic [31:0] fl, input logic [31:0] exp);
        bus.src_valid    = 1'b1;
        bus.src          = s;
        bus.fraction_len = fl;
        step();
        bus.src_valid = 1'b0;
        step();
        step();
        check({tag, "/early"}, {31'b0, bus.dst_valid}, 32'd0);
        step();
        check({tag, "/vld"}, {31'b0, bus.dst_valid}, 32'd1);
        check(tag, bus.dst, exp);
    endtask

    logic [31:0] st_src [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] st_exp [8] = '{32'h00000001, 32'h00000200, 32'h00000003, 32'h00000400,
                               32'h00000005, 32'h00000600, 32'h00000007, 32'h00000800};
    logic        vpat   [11];
    logic [31:0] e;
    int          opi;
    int          ecnt;

    initial begin
        // Reset held with live traffic: outputs stay cleared
        rstn             = 1'b0;
        enable           = 1'b1;
        bus.src_valid    = 1'b1;
        bus.src          = 32'h3F800000;
        bus.fraction_len = 32'd16;
        step();
        check("rst/vld0", {31'b0, bus.dst_valid}, 32'd0);
        check("rst/dst0", bus.dst, 32'd0);
        step();
        check("rst/vld1", {31'b0, bus.dst_valid}, 32'd0);
        check("rst/dst1", bus.dst, 32'd0);
        bus.src_valid = 1'b0;
        rstn          = 1'b1;
        step();
        step();
        check("rel/vld", {31'b0, bus.dst_valid}, 32'd0);

        // Directed values
        single("one_f16",   32'h3F800000, 32'd16, 32'h00010000);
        single("m2p5_f0",   32'hC0200000, 32'd0,  32'hFFFFFFFD);
        single("0p75_f0",   32'h3F400000, 32'd0,  32'h00000001);
        single("0p25_f0",   32'h3E800000, 32'd0,  32'h00000000);
        single("m0p25_f0",  32'hBE800000, 32'd0,  32'h00000000);
        single("1p5_f0",    32'h3FC00000, 32'd0,  32'h00000002);
        single("m1p5_f0",   32'hBFC00000, 32'd0,  32'hFFFFFFFE);
        single("3_f1",      32'h40400000, 32'd1,  32'h00000006);
        single("m3_f2",     32'hC0400000, 32'd2,  32'hFFFFFFF4);
        single("tiny_f0",   32'h30800000, 32'd0,  32'h00000000);
        single("3e9_f0",    32'h4F32D05E, 32'd0,  32'h7FFFFFFF);
        single("m2p31_f0",  32'hCF000000, 32'd0,  32'h80000000);
        single("m3e9_f0",   32'hCF32D05E, 32'd0,  32'h80000000);
        single("2p32_f0",   32'h4F800000, 32'd0,  32'h7FFFFFFF);
        single("one_f31",   32'h3F800000, 32'd31, 32'h7FFFFFFF);
        single("one_f40",   32'h3F800000, 32'd40, 32'h7FFFFFFF);
        single("half_f40",  32'h3F000000, 32'd40, 32'h40000000);
        single("half_fmax", 32'h3F000000, 32'hFFFFFFFF, 32'h40000000);
        single("nan",       32'h7FC00000, 32'd0,  32'h00000000);
        single("pinf",      32'h7F800000, 32'd0,  32'h7FFFFFFF);
        single("ninf",      32'hFF800000, 32'd0,  32'h80000000);
        single("denorm",    32'h00000001, 32'd0,  32'h00000000);
        single("negzero",   32'h80000000, 32'd8,  32'h00000000);

        // Stream of 8 with alternating F and a 2-cycle stall after the 4th
        opi  = 0;
        ecnt = 0;
        for (int i = 0; i < 13; i++) begin
            enable = (i != 4 && i != 5);
            if (opi < 8) begin
                bus.src_valid    = 1'b1;
                bus.src          = st_src[opi];
                bus.fraction_len = (opi % 2 != 0) ? 32'd8 : 32'd0;
            end else begin
                bus.src_valid = 1'b0;
            end
            step();
            if (enable) begin
                if (opi < 8) opi++;
                ecnt++;
                if (ecnt >= 4) begin
                    check($sformatf("stream/vld%0d", i), {31'b0, bus.dst_valid}, 32'd1);
                    check($sformatf("stream/dst%0d", i), bus.dst, st_exp[ecnt-4]);
                end else begin
                    check($sformatf("stream/idle%0d", i), {31'b0, bus.dst_valid}, 32'd0);
                end
            end else begin
                check($sformatf("stall/vld%0d", i), {31'b0, bus.dst_valid}, 32'd1);
                check($sformatf("stall/dst%0d", i), bus.dst, st_exp[ecnt-4]);
            end
        end
        enable        = 1'b1;
        bus.src_valid = 1'b0;
        step();
        check("drain/vld", {31'b0, bus.dst_valid}, 32'd0);
        check("drain/hold", bus.dst, 32'h00000800);

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            bus.src_valid    = 1'b1;
            bus.src          = 32'h40400000;
            bus.fraction_len = 32'd4;
            step();
        end
        bus.src_valid = 1'b0;
        rstn          = 1'b0;
        #1;
        check("arst/vld", {31'b0, bus.dst_valid}, 32'd0);
        check("arst/dst", bus.dst, 32'd0);
        #3;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_rst/vld%0d", i), {31'b0, bus.dst_valid}, 32'd0);
            check($sformatf("post_rst/dst%0d", i), bus.dst, 32'd0);
        end
        single("after_rst", 32'h3F800000, 32'd16, 32'h00010000);

        // Bubbles interleaved 1:1 with valid operands
        for (int i = 0; i < 11; i++) vpat[i] = (i < 8) && (i % 2 == 0);
        for (int i = 0; i < 11; i++) begin
            bus.src_valid    = vpat[i];
            bus.src          = 32'h3F800000;
            bus.fraction_len = i;
            step();
            if (i >= 3) begin
                check($sformatf("bubble/vld%0d", i), {31'b0, bus.dst_valid}, {31'b0, vpat[i-3]});
                if (vpat[i-3]) begin
                    e = 32'd1 << (i - 3);
                    check($sformatf("bubble/dst%0d", i), bus.dst, e);
                end
            end else begin
                check($sformatf("bubble/vld%0d", i), {31'b0, bus.dst_valid}, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
